// File: rtl/config_memory_pkg.sv
// Shared defaults and request encoding for config_memory.
package config_memory_pkg;

  localparam int MEM_WIDTH_DEF = 32;
  localparam int MEM_DEPTH_DEF = 32;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage : config_memory_pkg

// File: rtl/config_memory_array.sv
// Single-port storage with a registered read port; MEM_RESET_CLEAR_EN makes
// reset also clear every word.
module config_memory_array
  import config_memory_pkg::*;
#(
  parameter  int WIDTH      = MEM_WIDTH_DEF,
  parameter  int DEPTH      = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d, rdata_q;

  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

`ifdef MEM_RESET_CLEAR_EN
  // NOTE: clearing a memory on reset forbids RAM-macro inference; only
  // pay for it when the build asks for cleared contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (!rst_i && we_i) mem_q[waddr_i] <= wdata_i;
  end
`endif

  assign rdata_o = rdata_q;

endmodule : config_memory_array

// File: rtl/config_memory.sv
// Single-port memory with valid/ready handshake and 1-cycle registered read.
// Define MEM_RESET_CLEAR_EN to have reset clear the whole array.
module config_memory
  import config_memory_pkg::*;
#(
  parameter  int WIDTH      = MEM_WIDTH_DEF,
  parameter  int DEPTH      = MEM_DEPTH_DEF,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  wr_rd_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  input  logic                  valid_i,
  output logic                  ready_o
);

  logic ready_d, ready_q;
  logic we, re;

  // Requests are never stalled: every sampled valid is acknowledged next cycle.
  always_comb begin
    ready_d = valid_i;
    we      = valid_i && (wr_rd_i == MEM_OP_WRITE);
    re      = valid_i && (wr_rd_i == MEM_OP_READ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ready_q <= 1'b0;
    else       ready_q <= ready_d;
  end

  config_memory_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (we),
    .waddr_i (addr_i),
    .wdata_i (wdata_i),
    .re_i    (re),
    .raddr_i (addr_i),
    .rdata_o (rdata_o)
  );

  assign ready_o = ready_q;

endmodule : config_memory

// File: tb/tb_config_memory.sv
// Directed vector table plus sweep and repeat sequences for config_memory.
module tb_config_memory;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  addr_i;
  logic        wr_rd_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        valid_i;
  logic        ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  config_memory dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .addr_i  (addr_i),
    .wr_rd_i (wr_rd_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .valid_i (valid_i),
    .ready_o (ready_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        rst;
    logic        valid;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one request across a rising edge, then settle before sampling.
  task automatic drive(input logic rst, input logic valid, input logic wr,
                       input logic [4:0] addr, input logic [31:0] wd);
    rst_i   = rst;
    valid_i = valid;
    wr_rd_i = wr;
    addr_i  = addr;
    wdata_i = wd;
    @(posedge clk_i);
    #1;
  endtask

  task automatic add(input string name, input logic rst, input logic valid, input logic wr,
                     input logic [4:0] addr, input logic [31:0] wd,
                     input logic exp_ready, input logic [31:0] exp_rdata);
    vec_t v;
    v.name = name; v.rst = rst; v.valid = valid; v.wr = wr; v.addr = addr;
    v.wdata = wd; v.exp_ready = exp_ready; v.exp_rdata = exp_rdata;
    vecs.push_back(v);
  endtask

  logic [31:0] model [32];
  logic [31:0] keep07, keep15;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; wr_rd_i = 1'b0; addr_i = '0; wdata_i = '0;

`ifdef MEM_RESET_CLEAR_EN
    keep07 = 32'h0;
    keep15 = 32'h0;
`else
    keep07 = 32'h11223344;
    keep15 = 32'h12153524;
`endif

    add("reset0",        1, 0, 0, 5'h00, 32'h0,        0, 32'h0);
    add("reset1",        1, 1, 1, 5'h01, 32'hFFFFFFFF, 0, 32'h0);
`ifdef MEM_RESET_CLEAR_EN
    add("clr_read0",     0, 1, 0, 5'h00, 32'h0,        1, 32'h0);
    add("clr_idle",      0, 0, 0, 5'h00, 32'h0,        0, 32'h0);
`endif
    add("wr_15",         0, 1, 1, 5'h15, 32'h12153524, 1, 32'h0);
    add("rd_15",         0, 1, 0, 5'h15, 32'h0,        1, 32'h12153524);
    add("wr_03_hold",    0, 1, 1, 5'h03, 32'hDEADBEEF, 1, 32'h12153524);
    add("rd_03_b2b",     0, 1, 0, 5'h03, 32'h0,        1, 32'hDEADBEEF);
    add("idle_wr",       0, 0, 1, 5'h03, 32'hFFFFFFFF, 0, 32'hDEADBEEF);
    add("rd_03_after",   0, 1, 0, 5'h03, 32'h0,        1, 32'hDEADBEEF);
    add("wr_07",         0, 1, 1, 5'h07, 32'h11223344, 1, 32'hDEADBEEF);
    add("rst_mid_wr",    1, 1, 1, 5'h07, 32'hA5A5A5A5, 0, 32'h0);
    add("rd_07_post",    0, 1, 0, 5'h07, 32'h0,        1, keep07);
    add("rd_15_post",    0, 1, 0, 5'h15, 32'h0,        1, keep15);
    add("idle_hold",     0, 0, 0, 5'h00, 32'h0,        0, keep15);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      check({vecs[i].name, "_ready"}, {31'b0, ready_o}, {31'b0, vecs[i].exp_ready});
      check({vecs[i].name, "_rdata"}, rdata_o, vecs[i].exp_rdata);
    end

    // Sweep every word with valid held high throughout.
    for (int a = 0; a < 32; a++) begin
      model[a] = $urandom;
      drive(0, 1, 1, 5'(a), model[a]);
      check($sformatf("sweep_wr_ready_%0d", a), {31'b0, ready_o}, 32'h1);
    end
    for (int a = 0; a < 32; a++) begin
      drive(0, 1, 0, 5'(a), 32'h0);
      check($sformatf("sweep_rd_ready_%0d", a), {31'b0, ready_o}, 32'h1);
      check($sformatf("sweep_rd_data_%0d", a), rdata_o, model[a]);
    end

    // Holding a request repeats it idempotently.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 1, 5'h1F, 32'hCAFEF00D);
      check($sformatf("rep_wr_ready_%0d", k), {31'b0, ready_o}, 32'h1);
      check($sformatf("rep_wr_hold_%0d", k), rdata_o, model[31]);
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 5'h1F, 32'h0);
      check($sformatf("rep_rd_data_%0d", k), rdata_o, 32'hCAFEF00D);
    end
    drive(0, 1, 0, 5'h00, 32'h0);
    check("rd_00_untouched", rdata_o, model[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_config_memory
